// File: rtl/logic_gate_pipe.sv
// WIDTH-bit bitwise gate unit (8 modes) with a STAGES-deep valid/ready pipeline,
// zero/all-ones result flags and a saturating count of completed output handshakes.
module logic_gate_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_ones,
  input  logic             clear_count,
  output logic [CNT_W-1:0] op_count
);

  logic [WIDTH-1:0] gate_y;
  logic             gate_zero, gate_ones;

  logic [STAGES:1]              vld_pipe;
  logic [STAGES:1][WIDTH-1:0]   y_pipe;
  logic [STAGES:1]              zero_pipe, ones_pipe;
  logic [STAGES:1]              ld;
  logic                         out_hs;

  always_comb begin
    case (in_op)
      3'd0:    gate_y = ~(in_a & in_b);
      3'd1:    gate_y = in_a & in_b;
      3'd2:    gate_y = in_a | in_b;
      3'd3:    gate_y = ~(in_a | in_b);
      3'd4:    gate_y = in_a ^ in_b;
      3'd5:    gate_y = ~(in_a ^ in_b);
      3'd6:    gate_y = ~in_a;
      default: gate_y = in_a;
    endcase
    gate_zero = ~|gate_y;
    gate_ones = &gate_y;
  end

  // Stage k may load when out_ready is high or any stage from k to the tail has
  // a hole; this is the unrolled form of "empty or itself advancing".
  always_comb begin
    for (int k = 1; k <= STAGES; k++) begin
      logic full;
      full = 1'b1;
      for (int j = k; j <= STAGES; j++) full = full & vld_pipe[j];
      ld[k] = out_ready | ~full;
    end
  end

  assign in_ready  = ld[1];
  assign out_valid = vld_pipe[STAGES];
  assign out_y     = y_pipe[STAGES];
  assign out_zero  = zero_pipe[STAGES];
  assign out_ones  = ones_pipe[STAGES];
  assign out_hs    = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      y_pipe    <= '0;
      zero_pipe <= '0;
      ones_pipe <= '0;
    end else begin
      if (ld[1]) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) begin
          y_pipe[1]    <= gate_y;
          zero_pipe[1] <= gate_zero;
          ones_pipe[1] <= gate_ones;
        end
      end
      for (int k = 2; k <= STAGES; k++) begin
        if (ld[k]) begin
          vld_pipe[k] <= vld_pipe[k-1];
          if (vld_pipe[k-1]) begin
            y_pipe[k]    <= y_pipe[k-1];
            zero_pipe[k] <= zero_pipe[k-1];
            ones_pipe[k] <= ones_pipe[k-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      op_count <= '0;
    else if (clear_count)            op_count <= '0;
    else if (out_hs && ~&op_count)   op_count <= op_count + 1'b1;
  end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench for logic_gate_pipe: stimulus pushes expected results, a monitor pops on handshakes.
module tb_logic_gate_pipe;
  localparam int W  = 16;
  localparam int ST = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [2:0]   in_op = '0;
  logic         clear_count = 1'b0;
  logic         rnd_mode = 1'b0, rnd_bit = 1'b1, rdy_force = 1'b1;
  logic         out_ready;
  assign out_ready = rnd_mode ? rnd_bit : rdy_force;

  logic         in_ready, out_valid, out_zero, out_ones;
  logic [W-1:0] out_y;
  logic [15:0]  op_count;
  logic         s_in_ready, s_out_valid, s_out_zero, s_out_ones;
  logic [W-1:0] s_out_y;
  logic [1:0]   s_op_count;

  logic_gate_pipe #(.WIDTH(W), .STAGES(ST), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_zero(out_zero), .out_ones(out_ones),
    .clear_count(clear_count), .op_count(op_count));

  logic_gate_pipe #(.WIDTH(W), .STAGES(ST), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_y(s_out_y), .out_zero(s_out_zero), .out_ones(s_out_ones),
    .clear_count(clear_count), .op_count(s_op_count));

  typedef struct {
    logic [W-1:0] y;
    logic         z;
    logic         o;
    int           cyc;
    bit           lat;
  } exp_t;

  exp_t q[$];
  int   compared = 0, mismatched = 0;
  int   cyc = 0;
  bit   lat_chk = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples just after the falling edge, pops on each pending output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_output: got %0h expected none", out_y);
        end else begin
          e = q.pop_front();
          chk("out_y", 32'(out_y), 32'(e.y));
          chk("out_zero", 32'(out_zero), 32'(e.z));
          chk("out_ones", 32'(out_ones), 32'(e.o));
          if (e.lat) chk("latency", cyc - e.cyc, ST);
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                      input logic [W-1:0] ey, input logic ez, input logic eo);
    int n;
    @(negedge clk);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end else begin
      q.push_back('{y: ey, z: ez, o: eo, cyc: cyc, lat: lat_chk});
    end
    @(posedge clk);
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
      #2;
    end
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] a_tab [10] = '{16'h0000, 16'hFFFF, 16'h1234, 16'h8001, 16'h00FF,
                               16'hFF00, 16'h5555, 16'hAAAA, 16'h0F0F, 16'h7FFE};
  logic [W-1:0] m_exp [8]  = '{16'hFA5F, 16'h05A0, 16'hAFF5, 16'h500A,
                               16'hAA55, 16'h55AA, 16'h5A5A, 16'hA5A5};
  logic [1:0]   sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    logic [W-1:0] ev;
    logic [2:0]   op;
    int tp, gaps, nrdy;
    bit seen;

    // reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_y", 32'(out_y), 0);
    chk("rst_out_zero", 32'(out_zero), 0);
    chk("rst_out_ones", 32'(out_ones), 0);
    chk("rst_op_count", 32'(op_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", 32'(in_ready), 1);

    // NAND truth table
    send(16'h0000, 16'h0000, 3'd0, 16'hFFFF, 1'b0, 1'b1);
    send(16'hFFFF, 16'hFFFF, 3'd0, 16'h0000, 1'b1, 1'b0);
    send(16'hF0F0, 16'hFF00, 3'd0, 16'h0FFF, 1'b0, 1'b0);
    drain();

    // all modes back to back, latency checked per result
    for (int i = 0; i < 8; i++) send(16'hA5A5, 16'h0FF0, 3'(i), m_exp[i], 1'b0, 1'b0);
    drain();
    chk("count_after_modes", 32'(op_count), 11);

    // reset mid-stream with results held in the pipe
    rdy_force = 1'b0;
    send(16'h1111, 16'h0000, 3'd7, 16'h1111, 1'b0, 1'b0);
    send(16'h2222, 16'h0000, 3'd7, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 chk("midstream_valid", 32'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 0);
    chk("async_rst_op_count", 32'(op_count), 0);
    chk("async_rst_out_y", 32'(out_y), 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rdy_force = 1'b1;
    send(16'h3C3C, 16'h00FF, 3'd0, 16'hFFC3, 1'b0, 1'b0);
    drain();

    // backpressure: fill, check stall, then random out_ready
    @(negedge clk);
    clear_count = 1'b1;
    @(negedge clk);
    clear_count = 1'b0;
    lat_chk = 1'b0;
    rdy_force = 1'b0;
    for (int i = 0; i < 10; i++) begin
      op = (i % 2 == 0) ? 3'd7 : 3'd6;
      ev = (op == 3'd7) ? a_tab[i] : ~a_tab[i];
      send(a_tab[i], 16'h1357, op, ev, ev == 16'h0000, ev == 16'hFFFF);
      if (i == ST - 1) begin
        @(negedge clk);
        in_valid = 1'b0;
        chk("stall_in_ready", 32'(in_ready), 0);
        rnd_mode = 1'b1;
      end
    end
    drain();
    rnd_mode = 1'b0;
    rdy_force = 1'b1;
    lat_chk = 1'b1;
    chk("count_after_bp", 32'(op_count), 10);

    // saturation on the CNT_W=2 instance
    @(negedge clk);
    clear_count = 1'b1;
    @(negedge clk);
    clear_count = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(16'h0100 + 16'(i), 16'h0000, 3'd7, 16'h0100 + 16'(i), 1'b0, 1'b0);
      drain();
      chk("sat_count", 32'(s_op_count), 32'(sat_exp[i]));
    end
    send(16'h0042, 16'h0000, 3'd7, 16'h0042, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) break;
    end
    clear_count = 1'b1;
    @(negedge clk);
    clear_count = 1'b0;
    #1;
    chk("clear_prio_sat", 32'(s_op_count), 0);
    chk("clear_prio_main", 32'(op_count), 0);
    drain();

    // throughput: 20 cycles of in_valid=out_ready=1
    tp = 0; gaps = 0; nrdy = 0; seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_a = 16'h0200 + 16'(c); in_b = '0; in_op = 3'd7; in_valid = 1'b1;
      if (!in_ready) nrdy++;
      q.push_back('{y: 16'h0200 + 16'(c), z: 1'b0, o: 1'b0, cyc: cyc, lat: 1'b1});
      if (out_valid) begin tp++; seen = 1'b1; end
      else if (seen) gaps++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (out_valid) tp++;
    else if (seen) gaps++;
    chk("tp_results", tp, 20 - ST + 1);
    chk("tp_gaps", gaps, 0);
    chk("tp_in_ready_drops", nrdy, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1);
  end
endmodule
